// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Collects eight rising-edge-triggered device interrupt lines into a pending
// register, filters them through a writable mask register and the CPU's global
// enable, and presents one request at a time to the microcode sequencer.
// Priority is fixed with bit 0 highest. Once a request is raised its vector is
// frozen until the sequencer acknowledges it or the request is withdrawn.
//
// Build option:
//   INTC_IRQ_SYNC_EN  when defined, every irq_in bit passes through a two-flop
//                     synchronizer before edge detection. Leave it undefined
//                     only when irq_in is already synchronous to clk.
//
// Reset is asynchronous and active-high (arst).

module interrupt_controller (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] irq_in,
    input  logic [7:0] z_bus,
    input  logic       irq_masks_wrt,
    input  logic       int_ack,
    input  logic       clear_all_ints,
    input  logic       irq_global_en,
    output logic       int_pending,
    output logic [7:0] int_vector,
    output logic [7:0] irq_masks,
    output logic [7:0] irq_status
);

    // Request handshake states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StAck  = 2'd2
    } state_e;

    state_e     state_q;
    logic [2:0] vec_q;
    logic       int_pending_q;

    logic [7:0] irq_samp;
    logic [7:0] prev_q;
    logic [7:0] irq_edge;

    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] masks_q;
    logic [7:0] masks_d;

    logic [7:0] eligible;
    logic [2:0] win_idx;
    logic       ack_take;
    logic [7:0] ack_clr;
    logic       vec_live;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
`ifdef INTC_IRQ_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    // Two-flop synchronizer per line; irq_in is asynchronous to clk.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_samp = sync2_q;
`else
    assign irq_samp = irq_in;
`endif

    // Previous sampled level; reset to 0 so a line already high at reset
    // release is seen as one rising edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prev_q <= 8'h00;
        end else begin
            prev_q <= irq_samp;
        end
    end

    assign irq_edge = irq_samp & ~prev_q;

    // ------------------------------------------------------------------
    // Pending and mask registers
    // ------------------------------------------------------------------

    // Only an acknowledge taken while requesting may retire the latched vector.
    always_comb begin
        ack_take = (state_q == StReq) && int_ack;
        ack_clr  = 8'h00;
        if (ack_take) begin
            ack_clr = 8'h01 << vec_q;
        end
    end

    // Clear-all dominates; otherwise a new edge wins over an acknowledge on
    // the same bit so that a re-assertion is never lost.
    always_comb begin
        pending_d = pending_q;
        if (clear_all_ints) begin
            pending_d = 8'h00;
        end else begin
            pending_d = (pending_q & ~ack_clr) | irq_edge;
        end
    end

    // Mask load from the Z bus on the write strobe.
    always_comb begin
        masks_d = masks_q;
        if (irq_masks_wrt) begin
            masks_d = z_bus;
        end
    end

    // Pending and mask state; readback is taken straight from these flops.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pending_q <= 8'h00;
            masks_q   <= 8'h00;
        end else begin
            pending_q <= pending_d;
            masks_q   <= masks_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Registered masks are used, so a mask write affects eligibility one
    // cycle after the strobe.
    always_comb begin
        eligible = 8'h00;
        if (irq_global_en) begin
            eligible = pending_q & masks_q;
        end
    end

    // Lowest set bit wins; scan downwards so the last hit is the lowest.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    // The latched request is still valid only while its bit is pending and
    // masked in.
    always_comb begin
        vec_live = pending_q[vec_q] & masks_q[vec_q];
    end

    // ------------------------------------------------------------------
    // Request state machine with registered request output
    // ------------------------------------------------------------------

    // Raise one request at a time, hold its vector, and insert one dead
    // cycle (StAck) after every acknowledge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= StIdle;
            vec_q         <= 3'd0;
            int_pending_q <= 1'b0;
        end else if (clear_all_ints) begin
            state_q       <= StIdle;
            int_pending_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (eligible != 8'h00) begin
                        state_q       <= StReq;
                        vec_q         <= win_idx;
                        int_pending_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (int_ack) begin
                        state_q       <= StAck;
                        int_pending_q <= 1'b0;
                    end else if (!vec_live || !irq_global_en) begin
                        // Withdrawn by a mask write or global disable.
                        state_q       <= StIdle;
                        int_pending_q <= 1'b0;
                    end
                end
                StAck: begin
                    state_q       <= StIdle;
                    int_pending_q <= 1'b0;
                end
                default: begin
                    state_q       <= StIdle;
                    int_pending_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign int_pending = int_pending_q;
    assign int_vector  = {4'b0000, vec_q, 1'b0};
    assign irq_masks   = masks_q;
    assign irq_status  = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios with literal
// expectations plus randomized traffic, all outputs checked every cycle
// against a behavioural model.
module tb_interrupt_controller;

`ifdef INTC_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic [7:0] z_bus = 8'h00;
    logic       irq_masks_wrt = 1'b0;
    logic       int_ack = 1'b0;
    logic       clear_all_ints = 1'b0;
    logic       irq_global_en = 1'b0;
    logic       int_pending;
    logic [7:0] int_vector;
    logic [7:0] irq_masks;
    logic [7:0] irq_status;

    int n_cmp = 0;
    int n_fail = 0;

    interrupt_controller dut (
        .clk            (clk),
        .arst           (arst),
        .irq_in         (irq_in),
        .z_bus          (z_bus),
        .irq_masks_wrt  (irq_masks_wrt),
        .int_ack        (int_ack),
        .clear_all_ints (clear_all_ints),
        .irq_global_en  (irq_global_en),
        .int_pending    (int_pending),
        .int_vector     (int_vector),
        .irq_masks      (irq_masks),
        .irq_status     (irq_status)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 = no request, 1 = requesting, 2 = dead cycle after acknowledge
    typedef struct {
        logic [7:0] mask;
        logic [7:0] pend;
        logic [7:0] prev;
        logic [7:0] d1;
        logic [7:0] d2;
        int         phase;
        int         vec;
    } mstate_t;

    mstate_t m;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t    n = s;
        logic [7:0] samp;
        logic [7:0] elig;
`ifdef INTC_IRQ_SYNC_EN
        samp = s.d2;
        n.d2 = s.d1;
        n.d1 = irq_in;
`else
        samp = irq_in;
`endif
        n.prev = samp;
        elig = irq_global_en ? (s.pend & s.mask) : 8'h00;
        if (clear_all_ints) begin
            n.pend = 8'h00;
            n.phase = 0;
        end else begin
            if (s.phase == 1 && int_ack) n.pend[s.vec] = 1'b0;
            n.pend = n.pend | (samp & ~s.prev);
            if (s.phase == 0) begin
                if (elig != 8'h00) begin
                    n.phase = 1;
                    n.vec = lowest(elig);
                end
            end else if (s.phase == 1) begin
                if (int_ack) n.phase = 2;
                else if (!(s.pend[s.vec] && s.mask[s.vec]) || !irq_global_en) n.phase = 0;
            end else begin
                n.phase = 0;
            end
        end
        if (irq_masks_wrt) n.mask = z_bus;
        return n;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) m <= '{default: 0};
        else m <= model_next(m);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("cmp_int_pending", 32'(int_pending), (m.phase == 1) ? 32'd1 : 32'd0);
        check("cmp_int_vector", 32'(int_vector), 32'(m.vec * 2));
        check("cmp_irq_masks", 32'(irq_masks), 32'(m.mask));
        check("cmp_irq_status", 32'(irq_status), 32'(m.pend));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse; returns once the resulting request (if any) is raised.
    task automatic pulse(input logic [7:0] bits);
        irq_in = bits;
        step(1);
        irq_in = 8'h00;
        step(LAT);
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] v);
        irq_masks_wrt = 1'b1;
        z_bus = v;
        step(1);
        irq_masks_wrt = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        #1 arst = 1'b1;
        #1;
        check("rst_int_pending", 32'(int_pending), 32'd0);
        check("rst_int_vector", 32'(int_vector), 32'h00);
        check("rst_irq_masks", 32'(irq_masks), 32'h00);
        check("rst_irq_status", 32'(irq_status), 32'h00);
        @(negedge clk);
        arst = 1'b0;

        // Simultaneous arrival and set/request latency
        irq_global_en = 1'b1;
        write_mask(8'hFF);
        irq_in = 8'h24;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) irq_in = 8'h00;
        end while (irq_status == 8'h00 && n < 10);
        check("set_latency", 32'(n), 32'(LAT));
        check("sim_status", 32'(irq_status), 32'h24);
        check("sim_req_pending", 32'(int_pending), 32'd0);
        step(1);
        check("sim_pending", 32'(int_pending), 32'd1);
        check("sim_vector", 32'(int_vector), 32'h04);
        do_ack();
        check("sim_ack_status", 32'(irq_status), 32'h20);
        check("sim_ack_pending", 32'(int_pending), 32'd0);
        step(1);
        check("sim_dead_cycle", 32'(int_pending), 32'd0);
        step(1);
        check("sim_next_pending", 32'(int_pending), 32'd1);
        check("sim_next_vector", 32'(int_vector), 32'h0A);
        do_ack();
        step(2);

        // Freeze in REQ
        pulse(8'h08);
        check("frz_vector", 32'(int_vector), 32'h06);
        pulse(8'h01);
        check("frz_hold_vector", 32'(int_vector), 32'h06);
        check("frz_status", 32'(irq_status), 32'h09);
        do_ack();
        step(2);
        check("frz_next_pending", 32'(int_pending), 32'd1);
        check("frz_next_vector", 32'(int_vector), 32'h00);
        do_ack();
        step(2);
        check("frz_idle", 32'(int_pending), 32'd0);

        // Masking
        write_mask(8'h00);
        pulse(8'h02);
        check("msk_status", 32'(irq_status), 32'h02);
        check("msk_no_req", 32'(int_pending), 32'd0);
        write_mask(8'h02);
        check("msk_readback", 32'(irq_masks), 32'h02);
        check("msk_not_yet", 32'(int_pending), 32'd0);
        step(1);
        check("msk_req", 32'(int_pending), 32'd1);
        check("msk_vector", 32'(int_vector), 32'h02);
        write_mask(8'h00);
        step(1);
        check("msk_withdraw", 32'(int_pending), 32'd0);
        check("msk_still_pending", 32'(irq_status), 32'h02);
        clear_all_ints = 1'b1;
        step(1);
        clear_all_ints = 1'b0;

        // Clear precedence
        write_mask(8'hFF);
        pulse(8'h81);
        check("clr_pre_status", 32'(irq_status), 32'h81);
        check("clr_pre_vector", 32'(int_vector), 32'h00);
        irq_in = 8'h10;
        step(LAT - 1);
        clear_all_ints = 1'b1;
        step(1);
        clear_all_ints = 1'b0;
        irq_in = 8'h00;
        check("clr_status", 32'(irq_status), 32'h00);
        check("clr_idle", 32'(int_pending), 32'd0);
        step(LAT + 2);
        check("clr_edge_dropped", 32'(irq_status), 32'h00);

        // New edge coincident with acknowledge on the same bit
        pulse(8'h04);
        check("eak_vector", 32'(int_vector), 32'h04);
        irq_in = 8'h04;
        step(LAT - 1);
        do_ack();
        irq_in = 8'h00;
        check("eak_status", 32'(irq_status), 32'h04);
        step(2);
        check("eak_rereq", 32'(int_pending), 32'd1);
        do_ack();
        step(2);

        // Asynchronous reset mid-REQ, and a line high across reset release
        pulse(8'h40);
        check("rst_pre_req", 32'(int_pending), 32'd1);
        #2 arst = 1'b1;
        #1;
        check("arst_int_pending", 32'(int_pending), 32'd0);
        check("arst_int_vector", 32'(int_vector), 32'h00);
        check("arst_irq_masks", 32'(irq_masks), 32'h00);
        check("arst_irq_status", 32'(irq_status), 32'h00);
        irq_in = 8'h80;
        @(negedge clk);
        arst = 1'b0;
        step(LAT);
        check("high_at_reset", 32'(irq_status), 32'h80);
        irq_in = 8'h00;
        clear_all_ints = 1'b1;
        step(1);
        clear_all_ints = 1'b0;

        // Randomized traffic
        write_mask(8'hFF);
        for (int i = 0; i < 2000; i++) begin
            irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            z_bus = 8'($urandom);
            irq_masks_wrt = ($urandom_range(0, 9) == 0);
            int_ack = ($urandom_range(0, 2) == 0);
            clear_all_ints = ($urandom_range(0, 40) == 0);
            irq_global_en = ($urandom_range(0, 11) != 0);
            step(1);
        end
        irq_in = 8'h00;
        irq_masks_wrt = 1'b0;
        int_ack = 1'b0;
        clear_all_ints = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
